alu_rs_param: RTL and testbench
===============================

# alu_rs_param

Parametrised ALU reservation station with age-ordered issue, same-cycle CDB/result bypass on dispatch, a registered result stage and a flush input. It sits between the issue stage (instruction queue plus register-file/ROB operand lookup) and the ROB/CDB. It holds non-load/store instructions until both operands resolve. It issues the oldest ready entry to the ALU each cycle and broadcasts the registered result to the ROB and back to its own entries.

## Interface
Parameters:
- DEPTH, 4: number of entries, 2..8.
- XLEN, 32: data/address width.
- TAG_W, 4: width of the rename tag.
- OP_W, 5: width of the ALU opcode.
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i. Tag 0 is reserved as NONE.

Ports:
- clk_in  in  1  clock; one clock domain.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  misprediction flush.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_op  in  OP_W  ALU opcode from the shared package; load/store ops are filtered upstream.
- disp_addr  in  XLEN  instruction PC.
- disp_imm  in  XLEN  immediate.
- disp_use_imm  in  1  second operand is the immediate.
- disp_vj, disp_vk  in  XLEN  operand values from regfile/ROB.
- disp_qj, disp_qk  in  TAG_W  producer tags; NONE means the value is valid.
- disp_tag  out  TAG_W  tag allocated this cycle; NONE when disp_ready is 0.
- cdb_active  in  1  external CDB broadcast valid.
- cdb_tag  in  TAG_W  external CDB tag.
- cdb_val  in  XLEN  external CDB value.
- res_valid  out  1  registered result valid.
- res_tag  out  TAG_W  registered result tag.
- res_val  out  XLEN  registered result value.
- res_jalr  out  1  registered: the result is a JALR target.
- res_jalr_addr  out  XLEN  registered JALR target.

## Operation
- Entry fields: busy, op, addr, vj, vk, qj, qk. Age is tracked by a DEPTH×DEPTH age matrix; row i bit j set means i is older than j.
- Allocation: the lowest-index free entry. disp_ready = !all_busy and depends only on state, not on disp_valid. A slot freed by an issue this cycle is not reusable until the next cycle.
- Operand capture on dispatch:
  - qj is forced to NONE for JAL, AUIPC and LUI.
  - If use_imm: vk=imm, qk=NONE.
  - A q matching cdb_tag while cdb_active, or matching res_tag while res_valid, is captured as a value with q=NONE. The CDB has priority if both match.
- Wakeup: every busy entry whose qj/qk matches an active cdb_tag or a valid res_tag takes the value and clears the tag at the edge.
- Ready: busy && qj==NONE && qk==NONE. Select the ready entry that is older than every other ready entry.
- Issue: the selected entry feeds the ALU and is cleared at the edge. The ALU outputs are registered into res_* at the same edge.
- Flush: at the edge, clears all busy bits, the age matrix and res_valid. Dispatch and issue in that cycle are discarded.
- Reset: all entries idle, age matrix 0. Reset values: res_valid=0, res_jalr=0, res_tag=NONE, res_val=0, res_jalr_addr=0. disp_ready=1 and disp_tag=TAG_BASE once out of reset.
- rdy_in=0: no state change; outputs hold.

## Timing
- Dispatch at edge N gives an entry that is visible in cycle N+1. The earliest issue is cycle N+1 if both operands are ready, and res_valid is seen in cycle N+2.
- A dependent instruction woken by res_* at edge N+2 issues in cycle N+2, so back-to-back dependent ALU ops are 1 cycle apart.
- res_valid is high for exactly one cycle per issue. At most one issue per cycle.
- Simultaneous events:
  - Dispatch, issue and wakeup in the same cycle all take effect.
  - The dispatch bypass covers a producer broadcasting in the dispatch cycle.
  - Reset dominates flush, and flush dominates everything else.

## Structure
- Shared package: opcode encodings (OP_W), NONE tag constant, JAL/AUIPC/LUI/JALR opcode identifiers.
- One sub-module: the existing combinational ALU, instantiated on the issue path. It produces result, jalr flag and target.
- Oldest-ready selection stays inline.

## Test plan
- Reset, then dispatch ADDI x1 (vj=5, imm=7, use_imm): disp_tag=1; two cycles later res_valid=1, res_tag=1, res_val=12.
- Dispatch A (tag 1, qj=9), then B (tag 2, ready), then drive CDB tag 9 value 3 for A: B issues first. A issues the cycle after its wakeup; result order is tag 2, then tag 1.
- DEPTH=4, dispatch 4 entries all waiting on tag 9: disp_ready=0 and disp_tag=NONE; a 5th disp_valid is not accepted. CDB tag 9 frees one entry per cycle; disp_ready is back to 1 the cycle after the first issue.
- Dispatch with disp_qk=9 in the cycle cdb_active, tag 9, value 0x10: the entry captures 0x10 with qk=NONE and issues the next cycle.
- Dependent chain ADD tag 1 → ADD tag 2 (qj=1): tag 2 issues in the cycle res_tag=1 is valid; results arrive on consecutive cycles.
- With 3 busy entries, assert flush together with disp_valid: next cycle all entries are free, res_valid=0 and nothing issues. Then hold rdy_in=0 for 3 cycles with a ready entry: no issue until rdy_in=1.

Source files
------------

// File: rtl/alu_rs_param_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings,
// the reserved NONE tag and opcode-class helpers.
package alu_rs_param_pkg;

    localparam int ALU_OP_W = 5;
    localparam int TAG_NONE = 0;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_LUI   = 5'd10,
        OP_AUIPC = 5'd11,
        OP_JAL   = 5'd12,
        OP_JALR  = 5'd13,
        OP_BEQ   = 5'd14,
        OP_BNE   = 5'd15,
        OP_BLT   = 5'd16,
        OP_BGE   = 5'd17,
        OP_BLTU  = 5'd18,
        OP_BGEU  = 5'd19
    } alu_op_e;

    // Ops whose first operand is the PC or nothing, so rs1 is never waited on.
    function automatic logic no_rs1(input logic [ALU_OP_W-1:0] op);
        return (op == OP_JAL) || (op == OP_AUIPC) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/alu_rs_param_alu.sv
// Combinational ALU on the reservation-station issue path: arithmetic/logic
// result, branch condition as 0/1, link address and JALR target.
module alu_rs_param_alu
    import alu_rs_param_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] vj,
    input  logic [XLEN-1:0] vk,
    output logic [XLEN-1:0] result,
    output logic            jalr,
    output logic [XLEN-1:0] target
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] sum;

    assign shamt  = vk[SH_W-1:0];
    assign sum    = vj + vk;
    assign target = {sum[XLEN-1:1], 1'b0};

    always_comb begin
        result = '0;
        jalr   = 1'b0;
        case (op)
            OP_W'(OP_ADD):   result = sum;
            OP_W'(OP_SUB):   result = vj - vk;
            OP_W'(OP_SLL):   result = vj << shamt;
            OP_W'(OP_SLT):   result = XLEN'($signed(vj) < $signed(vk));
            OP_W'(OP_SLTU):  result = XLEN'(vj < vk);
            OP_W'(OP_XOR):   result = vj ^ vk;
            OP_W'(OP_SRL):   result = vj >> shamt;
            OP_W'(OP_SRA):   result = $unsigned($signed(vj) >>> shamt);
            OP_W'(OP_OR):    result = vj | vk;
            OP_W'(OP_AND):   result = vj & vk;
            OP_W'(OP_LUI):   result = vk;
            OP_W'(OP_AUIPC): result = addr + vk;
            OP_W'(OP_JAL):   result = addr + XLEN'(4);
            OP_W'(OP_JALR): begin
                result = addr + XLEN'(4);
                jalr   = 1'b1;
            end
            OP_W'(OP_BEQ):   result = XLEN'(vj == vk);
            OP_W'(OP_BNE):   result = XLEN'(vj != vk);
            OP_W'(OP_BLT):   result = XLEN'($signed(vj) < $signed(vk));
            OP_W'(OP_BGE):   result = XLEN'($signed(vj) >= $signed(vk));
            OP_W'(OP_BLTU):  result = XLEN'(vj < vk);
            OP_W'(OP_BGEU):  result = XLEN'(vj >= vk);
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rs_param.sv
// ALU reservation station: holds ALU ops until operands resolve, issues the
// oldest ready entry each cycle and registers the ALU result for ROB/CDB.
module alu_rs_param
    import alu_rs_param_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 5,
    parameter int TAG_BASE = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_addr,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic             disp_use_imm,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    output logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_active,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_val,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_val,
    output logic             res_jalr,
    output logic [XLEN-1:0]  res_jalr_addr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

    function automatic logic hit(input logic [TAG_W-1:0] q, input logic act,
                                 input logic [TAG_W-1:0] tag);
        return act && (q != NONE) && (q == tag);
    endfunction

    logic [DEPTH-1:0]              ent_busy;
    logic [OP_W-1:0]               ent_op   [DEPTH];
    logic [XLEN-1:0]               ent_addr [DEPTH];
    logic [XLEN-1:0]               ent_vj   [DEPTH];
    logic [XLEN-1:0]               ent_vk   [DEPTH];
    logic [TAG_W-1:0]              ent_qj   [DEPTH];
    logic [TAG_W-1:0]              ent_qk   [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0]   ent_age;
    logic [DEPTH-1:0][DEPTH-1:0]   age_next;

    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             disp_fire;
    logic [XLEN-1:0]  d_vj, d_vk;
    logic [TAG_W-1:0] d_qj, d_qk;

    logic [DEPTH-1:0] ready;
    logic             oldest;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [XLEN-1:0]  iss_vj, iss_vk;
    logic [XLEN-1:0]  alu_result, alu_target;
    logic             alu_jalr;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!ent_busy[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign disp_ready = free_found;
    assign disp_tag   = free_found ? TAG_W'(TAG_BASE) + TAG_W'(free_idx) : NONE;
    assign disp_fire  = disp_valid && free_found;

    always_comb begin
        d_qj = no_rs1(ALU_OP_W'(disp_op)) ? NONE : disp_qj;
        d_vj = disp_vj;
        if (hit(d_qj, cdb_active, cdb_tag)) begin
            d_vj = cdb_val;
            d_qj = NONE;
        end else if (hit(d_qj, res_valid, res_tag)) begin
            d_vj = res_val;
            d_qj = NONE;
        end
        d_qk = disp_use_imm ? NONE : disp_qk;
        d_vk = disp_use_imm ? disp_imm : disp_vk;
        if (hit(d_qk, cdb_active, cdb_tag)) begin
            d_vk = cdb_val;
            d_qk = NONE;
        end else if (hit(d_qk, res_valid, res_tag)) begin
            d_vk = res_val;
            d_qk = NONE;
        end
    end

    // A tag matching the live result counts as resolved, so dependants issue
    // in the same cycle with res_val forwarded straight into the ALU.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = ent_busy[i]
                    && (ent_qj[i] == NONE || hit(ent_qj[i], res_valid, res_tag))
                    && (ent_qk[i] == NONE || hit(ent_qk[i], res_valid, res_tag));
        end
        oldest    = 1'b0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            oldest = ready[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && !ent_age[i][j])
                    oldest = 1'b0;
            end
            if (oldest && !sel_valid) begin
                sel_idx   = IDX_W'(i);
                sel_valid = 1'b1;
            end
        end
        iss_vj = (ent_qj[sel_idx] == NONE) ? ent_vj[sel_idx] : res_val;
        iss_vk = (ent_qk[sel_idx] == NONE) ? ent_vk[sel_idx] : res_val;
    end

    always_comb begin
        age_next = ent_age;
        if (disp_fire) begin
            age_next[free_idx] = '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                age_next[j][free_idx] = ent_busy[j];
        end
        if (sel_valid) begin
            age_next[sel_idx] = '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                age_next[j][sel_idx] = 1'b0;
        end
    end

    alu_rs_param_alu #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_alu (
        .op     (ent_op[sel_idx]),
        .addr   (ent_addr[sel_idx]),
        .vj     (iss_vj),
        .vk     (iss_vk),
        .result (alu_result),
        .jalr   (alu_jalr),
        .target (alu_target)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ent_busy      <= '0;
            ent_age       <= '0;
            res_valid     <= 1'b0;
            res_jalr      <= 1'b0;
            res_tag       <= NONE;
            res_val       <= '0;
            res_jalr_addr <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                ent_busy  <= '0;
                ent_age   <= '0;
                res_valid <= 1'b0;
                res_jalr  <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (hit(ent_qj[i], cdb_active, cdb_tag)) begin
                        ent_vj[i] <= cdb_val;
                        ent_qj[i] <= NONE;
                    end else if (hit(ent_qj[i], res_valid, res_tag)) begin
                        ent_vj[i] <= res_val;
                        ent_qj[i] <= NONE;
                    end
                    if (hit(ent_qk[i], cdb_active, cdb_tag)) begin
                        ent_vk[i] <= cdb_val;
                        ent_qk[i] <= NONE;
                    end else if (hit(ent_qk[i], res_valid, res_tag)) begin
                        ent_vk[i] <= res_val;
                        ent_qk[i] <= NONE;
                    end
                end
                if (sel_valid)
                    ent_busy[sel_idx] <= 1'b0;
                if (disp_fire) begin
                    ent_busy[free_idx] <= 1'b1;
                    ent_op[free_idx]   <= disp_op;
                    ent_addr[free_idx] <= disp_addr;
                    ent_vj[free_idx]   <= d_vj;
                    ent_vk[free_idx]   <= d_vk;
                    ent_qj[free_idx]   <= d_qj;
                    ent_qk[free_idx]   <= d_qk;
                end
                ent_age   <= age_next;
                res_valid <= sel_valid;
                res_jalr  <= sel_valid && alu_jalr;
                if (sel_valid) begin
                    res_tag       <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
                    res_val       <= alu_result;
                    res_jalr_addr <= alu_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_param.sv
// Directed bench for alu_rs_param: single-op vector table plus hand-written
// ordering, full-station, bypass, dependency, flush and stall sequences.
module tb_alu_rs_param;
    import alu_rs_param_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        disp_valid, disp_ready, disp_use_imm;
    logic [4:0]  disp_op;
    logic [31:0] disp_addr, disp_imm, disp_vj, disp_vk;
    logic [3:0]  disp_qj, disp_qk, disp_tag;
    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        res_valid, res_jalr;
    logic [3:0]  res_tag;
    logic [31:0] res_val, res_jalr_addr;

    int checks = 0;
    int errors = 0;

    alu_rs_param #(
        .DEPTH    (4),
        .XLEN     (32),
        .TAG_W    (4),
        .OP_W     (5),
        .TAG_BASE (1)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_addr     (disp_addr),
        .disp_imm      (disp_imm),
        .disp_use_imm  (disp_use_imm),
        .disp_vj       (disp_vj),
        .disp_vk       (disp_vk),
        .disp_qj       (disp_qj),
        .disp_qk       (disp_qk),
        .disp_tag      (disp_tag),
        .cdb_active    (cdb_active),
        .cdb_tag       (cdb_tag),
        .cdb_val       (cdb_val),
        .res_valid     (res_valid),
        .res_tag       (res_tag),
        .res_val       (res_val),
        .res_jalr      (res_jalr),
        .res_jalr_addr (res_jalr_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        alu_op_e     op;
        logic [31:0] addr;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  qj;
        logic [31:0] exp_val;
        logic        exp_jalr;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next();
        @(negedge clk_in);
    endtask

    task automatic idle();
        disp_valid   = 1'b0;
        disp_op      = '0;
        disp_addr    = '0;
        disp_imm     = '0;
        disp_use_imm = 1'b0;
        disp_vj      = '0;
        disp_vk      = '0;
        disp_qj      = '0;
        disp_qk      = '0;
        flush        = 1'b0;
        cdb_active   = 1'b0;
        cdb_tag      = '0;
        cdb_val      = '0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [31:0] imm, input logic use_imm,
                        input logic [3:0] qj, input logic [3:0] qk);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_addr    = addr;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_imm     = imm;
        disp_use_imm = use_imm;
        disp_qj      = qj;
        disp_qk      = qk;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        next();
        next();
        rst_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{OP_ADD,   32'h0,    32'd5,        32'd0,        32'd7,         1'b1, 4'd0, 32'd12,        1'b0, 32'h0});
        vecs.push_back('{OP_SUB,   32'h0,    32'd3,        32'd5,        32'd0,         1'b0, 4'd0, 32'hFFFF_FFFE, 1'b0, 32'h0});
        vecs.push_back('{OP_SLL,   32'h0,    32'd1,        32'd31,       32'd0,         1'b0, 4'd0, 32'h8000_0000, 1'b0, 32'h0});
        vecs.push_back('{OP_SLT,   32'h0,    32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0, 4'd0, 32'd1,         1'b0, 32'h0});
        vecs.push_back('{OP_SLTU,  32'h0,    32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0, 4'd0, 32'd0,         1'b0, 32'h0});
        vecs.push_back('{OP_XOR,   32'h0,    32'hF0F0,     32'h0FF0,     32'd0,         1'b0, 4'd0, 32'hFF00,      1'b0, 32'h0});
        vecs.push_back('{OP_SRA,   32'h0,    32'h8000_0000, 32'd4,       32'd0,         1'b0, 4'd0, 32'hF800_0000, 1'b0, 32'h0});
        vecs.push_back('{OP_SRL,   32'h0,    32'h8000_0000, 32'd4,       32'd0,         1'b0, 4'd0, 32'h0800_0000, 1'b0, 32'h0});
        vecs.push_back('{OP_OR,    32'h0,    32'h0F00,     32'h00F0,     32'd0,         1'b0, 4'd0, 32'h0FF0,      1'b0, 32'h0});
        vecs.push_back('{OP_AND,   32'h0,    32'hFF00,     32'h0FF0,     32'd0,         1'b0, 4'd0, 32'h0F00,      1'b0, 32'h0});
        vecs.push_back('{OP_LUI,   32'h0,    32'hDEAD,     32'd0,        32'h1234_5000, 1'b1, 4'd5, 32'h1234_5000, 1'b0, 32'h0});
        vecs.push_back('{OP_AUIPC, 32'h1000, 32'd0,        32'd0,        32'h2000,      1'b1, 4'd7, 32'h3000,      1'b0, 32'h0});
        vecs.push_back('{OP_JAL,   32'h100,  32'd0,        32'd0,        32'h40,        1'b1, 4'd3, 32'h104,       1'b0, 32'h0});
        vecs.push_back('{OP_JALR,  32'h200,  32'h1001,     32'd0,        32'd4,         1'b1, 4'd0, 32'h204,       1'b1, 32'h1004});
        vecs.push_back('{OP_BLT,   32'h0,    32'hFFFF_FFFF, 32'd0,       32'd0,         1'b0, 4'd0, 32'd1,         1'b0, 32'h0});
        vecs.push_back('{OP_BGEU,  32'h0,    32'hFFFF_FFFF, 32'd0,       32'd0,         1'b0, 4'd0, 32'd1,         1'b0, 32'h0});
        vecs.push_back('{OP_BNE,   32'h0,    32'd5,        32'd5,        32'd0,         1'b0, 4'd0, 32'd0,         1'b0, 32'h0});

        // Reset values
        do_reset();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_res_val", res_val, 0);
        check("rst_res_jalr", res_jalr, 0);
        check("rst_res_jalr_addr", res_jalr_addr, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_disp_tag", disp_tag, 1);

        // Single-op table: result two cycles after dispatch
        foreach (vecs[i]) begin
            check($sformatf("v%0d_disp_tag", i), disp_tag, 1);
            disp(vecs[i].op, vecs[i].addr, vecs[i].vj, vecs[i].vk, vecs[i].imm,
                 vecs[i].use_imm, vecs[i].qj, 4'd0);
            next();
            idle();
            check($sformatf("v%0d_early_valid", i), res_valid, 0);
            next();
            check($sformatf("v%0d_res_valid", i), res_valid, 1);
            check($sformatf("v%0d_res_tag", i), res_tag, 1);
            check($sformatf("v%0d_res_val", i), res_val, vecs[i].exp_val);
            check($sformatf("v%0d_res_jalr", i), res_jalr, vecs[i].exp_jalr);
            if (vecs[i].exp_jalr)
                check($sformatf("v%0d_jalr_addr", i), res_jalr_addr, vecs[i].exp_tgt);
        end

        // Ready younger entry issues before an older waiting one
        do_reset();
        check("ord_tag_a", disp_tag, 1);
        disp(OP_ADD, 0, 32'd0, 32'd1, 0, 1'b0, 4'd9, 4'd0);
        next();
        check("ord_tag_b", disp_tag, 2);
        disp(OP_ADD, 0, 32'd2, 32'd3, 0, 1'b0, 4'd0, 4'd0);
        next();
        idle();
        cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'd3;
        check("ord_c2_valid", res_valid, 0);
        next();
        idle();
        check("ord_first_valid", res_valid, 1);
        check("ord_first_tag", res_tag, 2);
        check("ord_first_val", res_val, 5);
        next();
        check("ord_second_valid", res_valid, 1);
        check("ord_second_tag", res_tag, 1);
        check("ord_second_val", res_val, 4);
        next();
        check("ord_done_valid", res_valid, 0);

        // Full station: back-pressure, then drain in age order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_tag%0d", i), disp_tag, 4'(i + 1));
            disp(OP_ADD, 0, 32'd0, 32'(10 + i), 0, 1'b0, 4'd9, 4'd0);
            next();
        end
        check("full_ready", disp_ready, 0);
        check("full_tag_none", disp_tag, 0);
        disp(OP_ADD, 0, 32'd1, 32'd1, 0, 1'b0, 4'd0, 4'd0);
        next();
        idle();
        check("full_ready_after5", disp_ready, 0);
        cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'd100;
        next();
        idle();
        check("full_issue_cycle_ready", disp_ready, 0);
        check("full_issue_cycle_valid", res_valid, 0);
        next();
        check("full_ready_back", disp_ready, 1);
        check("full_tag_back", disp_tag, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_res%0d_valid", i), res_valid, 1);
            check($sformatf("full_res%0d_tag", i), res_tag, 4'(i + 1));
            check($sformatf("full_res%0d_val", i), res_val, 32'(110 + i));
            next();
        end
        check("full_drained", res_valid, 0);

        // Dispatch captures a same-cycle CDB broadcast
        do_reset();
        disp(OP_ADD, 0, 32'd1, 32'hDEAD, 0, 1'b0, 4'd0, 4'd9);
        cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'h10;
        next();
        idle();
        check("byp_c1_valid", res_valid, 0);
        next();
        check("byp_valid", res_valid, 1);
        check("byp_val", res_val, 32'h11);

        // Dependent chain: results on consecutive cycles
        do_reset();
        disp(OP_ADD, 0, 32'd2, 32'd3, 0, 1'b0, 4'd0, 4'd0);
        next();
        check("chain_tag2", disp_tag, 2);
        disp(OP_ADD, 0, 32'd0, 32'd10, 0, 1'b0, 4'd1, 4'd0);
        next();
        idle();
        check("chain_r1_valid", res_valid, 1);
        check("chain_r1_tag", res_tag, 1);
        check("chain_r1_val", res_val, 5);
        next();
        check("chain_r2_valid", res_valid, 1);
        check("chain_r2_tag", res_tag, 2);
        check("chain_r2_val", res_val, 15);

        // Flush discards entries and the same-cycle dispatch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 0, 32'd0, 32'd1, 0, 1'b0, 4'd9, 4'd0);
            next();
        end
        check("fl_tag_before", disp_tag, 4);
        disp(OP_ADD, 0, 32'd1, 32'd1, 0, 1'b0, 4'd0, 4'd0);
        flush = 1'b1;
        next();
        idle();
        check("fl_ready", disp_ready, 1);
        check("fl_tag", disp_tag, 1);
        check("fl_res_valid", res_valid, 0);
        cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'd50;
        next();
        idle();
        check("fl_no_issue1", res_valid, 0);
        next();
        check("fl_no_issue2", res_valid, 0);

        // rdy_in low freezes a ready entry
        disp(OP_ADD, 0, 32'd7, 32'd8, 0, 1'b0, 4'd0, 4'd0);
        next();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next();
            check($sformatf("stall%0d_valid", i), res_valid, 0);
            check($sformatf("stall%0d_tag", i), disp_tag, 2);
        end
        rdy_in = 1'b1;
        next();
        check("stall_res_valid", res_valid, 1);
        check("stall_res_tag", res_tag, 1);
        check("stall_res_val", res_val, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
